// File: rtl/iomem_timer.sv
// -----------------------------------------------------------------------------
// iomem_timer
//
// Memory-mapped timer/compare peripheral, responder on the SoC iomem_* bus.
// Provides a 16-bit prescaler feeding a 32-bit up-counter, a compare register
// with optional auto-reload, and a sticky match flag that drives a level irq.
//
// Register window (offset = iomem_addr[7:0]):
//   0x00 CTRL     [0] en, [1] autoreload, [2] irq_en
//   0x04 PRESCALE [15:0]
//   0x08 COUNT    [31:0] live counter, write loads
//   0x0C COMPARE  [31:0]
//   0x10 STATUS   [0] match_flag, write-1-to-clear (byte 0)
//   other offsets acknowledged, read 0, writes ignored
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   iomem_valid  request valid, held until iomem_ready
//   iomem_ready  one-cycle acknowledge
//   iomem_wstrb  byte write strobes, all zero = read
//   iomem_addr   byte address
//   iomem_wdata  write data
//   iomem_rdata  read data, zero except during iomem_ready
//   irq          level interrupt = match_flag & irq_en
// -----------------------------------------------------------------------------
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  // Register offsets inside the 256-byte window.
  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_PRESCALE = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_COMPARE  = 8'h0C;
  localparam logic [7:0] OFF_STATUS   = 8'h10;

  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } ctrl_t;

  // Byte-lane merge used by every strobed 32-bit register.
  function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ctrl_t       r_ctrl;
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;
  logic        r_ready;
  logic [31:0] r_rdata;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       w_sel;
  logic       w_acc;
  logic       w_wr;
  logic [7:0] w_off;
  logic       w_wr_ctrl;
  logic       w_wr_prescale;
  logic       w_wr_count;
  logic       w_wr_compare;
  logic       w_clr_match;

  assign w_sel = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
  // The acknowledge edge: a selected request while no ready pulse is out.
  // Gating on !r_ready stops a held request from being taken twice.
  assign w_acc = w_sel && !r_ready;
  assign w_wr  = w_acc && (iomem_wstrb != 4'b0000);
  assign w_off = iomem_addr[7:0];

  assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
  assign w_wr_prescale = w_wr && (w_off == OFF_PRESCALE);
  assign w_wr_count    = w_wr && (w_off == OFF_COUNT);
  assign w_wr_compare  = w_wr && (w_off == OFF_COMPARE);
  assign w_clr_match   = w_wr && (w_off == OFF_STATUS) &&
                         iomem_wstrb[0] && iomem_wdata[0];

  // ---------------------------------------------------------------------------
  // Prescaler and counter
  // ---------------------------------------------------------------------------
  logic        w_tick;
  logic        w_match;
  logic [31:0] w_count_inc;

  // '>=' rather than '==': if PRESCALE is lowered below a running pcnt the
  // next tick comes immediately instead of after a 16-bit wrap. In steady
  // state pcnt never exceeds PRESCALE, so the two forms agree.
  assign w_tick      = r_ctrl.en && (r_pcnt >= r_prescale);
  assign w_match     = w_tick && (r_count == r_compare);
  assign w_count_inc = r_count + 32'd1;

  ctrl_t       w_ctrl_nxt;
  logic [15:0] w_prescale_nxt;
  logic [15:0] w_pcnt_nxt;
  logic [31:0] w_count_nxt;
  logic [31:0] w_compare_nxt;
  logic        w_match_nxt;
  logic [31:0] w_rdata_nxt;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_ctrl_nxt     = r_ctrl;
    w_prescale_nxt = r_prescale;
    w_pcnt_nxt     = r_pcnt;
    w_count_nxt    = r_count;
    w_compare_nxt  = r_compare;
    w_match_nxt    = r_match;

    if (w_wr_ctrl && iomem_wstrb[0]) begin
      w_ctrl_nxt = ctrl_t'(iomem_wdata[2:0]);
    end

    if (w_wr_prescale) begin
      if (iomem_wstrb[0]) w_prescale_nxt[7:0]  = iomem_wdata[7:0];
      if (iomem_wstrb[1]) w_prescale_nxt[15:8] = iomem_wdata[15:8];
    end

    if (w_wr_compare) begin
      w_compare_nxt = merge32(r_compare, iomem_wdata, iomem_wstrb);
    end

    // The enable seen here is the pre-write value, so a CTRL write that
    // clears en still lets this cycle's tick through.
    if (!r_ctrl.en) begin
      w_pcnt_nxt = 16'd0;
    end else if (w_tick) begin
      w_pcnt_nxt = 16'd0;
    end else begin
      w_pcnt_nxt = r_pcnt + 16'd1;
    end

    // A COUNT write overrides the tick's update; pcnt was already cleared
    // above by the same tick, so the new value gets a full prescale period.
    if (w_wr_count) begin
      w_count_nxt = merge32(r_count, iomem_wdata, iomem_wstrb);
    end else if (w_tick) begin
      if (w_match && r_ctrl.autoreload) begin
        w_count_nxt = 32'd0;
      end else begin
        w_count_nxt = w_count_inc;
      end
    end

    // Set has priority over a same-cycle write-1-to-clear.
    w_match_nxt = w_match || (r_match && !w_clr_match);
  end

  // Read mux on pre-write values; anything unmapped reads as zero.
  always_comb begin
    w_rdata_nxt = 32'd0;
    if (w_acc) begin
      case (w_off)
        OFF_CTRL:     w_rdata_nxt = {29'd0, r_ctrl};
        OFF_PRESCALE: w_rdata_nxt = {16'd0, r_prescale};
        OFF_COUNT:    w_rdata_nxt = r_count;
        OFF_COMPARE:  w_rdata_nxt = r_compare;
        OFF_STATUS:   w_rdata_nxt = {31'd0, r_match};
        default:      w_rdata_nxt = 32'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl     <= '0;
      r_prescale <= 16'd0;
      r_pcnt     <= 16'd0;
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_match    <= 1'b0;
      r_ready    <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_prescale <= w_prescale_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_count    <= w_count_nxt;
      r_compare  <= w_compare_nxt;
      r_match    <= w_match_nxt;
      r_ready    <= w_acc;
      r_rdata    <= w_rdata_nxt;
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign irq         = r_match && r_ctrl.irq_en;

endmodule
